// File: rtl/aes_inv_cipher_iter_pkg.sv
// AES-128 shared constants and helpers: S-box tables, round constants, FSM state, key-schedule steps.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_INIT,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    // Indexed directly by the 4-bit round counter; entries outside 1..10 are unused.
    localparam logic [7:0] RCON [16] = '{
        8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // SubWord(RotWord(w)), word byte 0 in [31:24].
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] fwd_key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h000000};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo fwd_key_step: the last three words fall out by XOR chaining, and the
    // recovered last word then regenerates the first one.
    function automatic logic [127:0] inv_key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Latency: combinational. Backpressure: none, pure function of st/rk/last.
// Ports: st (state in), rk (round key for this round), last (skip InvMixColumns), nxt (state out).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] nxt
);

    logic [7:0] sb [16];
    logic [7:0] ib [16];
    logic [7:0] mb [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = st[127 - 8*i -: 8];
        end
        // Byte index = row + 4*col; row r is rotated right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ib[r + 4*c] = INV_SBOX[sb[r + 4*((c - r + 4) % 4)]] ^ rk[127 - 8*(r + 4*c) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mb[4*c]   = gf_mul(ib[4*c], 8'h0e) ^ gf_mul(ib[4*c+1], 8'h0b)
                      ^ gf_mul(ib[4*c+2], 8'h0d) ^ gf_mul(ib[4*c+3], 8'h09);
            mb[4*c+1] = gf_mul(ib[4*c], 8'h09) ^ gf_mul(ib[4*c+1], 8'h0e)
                      ^ gf_mul(ib[4*c+2], 8'h0b) ^ gf_mul(ib[4*c+3], 8'h0d);
            mb[4*c+2] = gf_mul(ib[4*c], 8'h0d) ^ gf_mul(ib[4*c+1], 8'h09)
                      ^ gf_mul(ib[4*c+2], 8'h0e) ^ gf_mul(ib[4*c+3], 8'h0b);
            mb[4*c+3] = gf_mul(ib[4*c], 8'h0b) ^ gf_mul(ib[4*c+1], 8'h0d)
                      ^ gf_mul(ib[4*c+2], 8'h09) ^ gf_mul(ib[4*c+3], 8'h0e);
        end
        nxt = '0;
        for (int i = 0; i < 16; i++) begin
            nxt[127 - 8*i -: 8] = last ? ib[i] : mb[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock, with a one-entry round-key-10 cache.
// Latency: out_valid 22 edges after accept (12 on cache hit); one block in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst_n; in_valid/in_ready/ct_in/key_in accept side; out_valid/out_ready/pt_out result side; busy.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter bit KEY_CACHE_EN = 1'b1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out,
    output logic         busy
);

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk;
    logic [127:0] key_reg;
    logic [127:0] cache_key;
    logic [127:0] rk10_cache;
    logic         cache_valid;

    logic [127:0] rk_fwd;
    logic [127:0] rk_prev;
    logic [127:0] round_out;
    logic         cache_hit;

    assign rk_fwd    = fwd_key_step(rk, RCON[cnt]);
    assign rk_prev   = inv_key_step(rk, RCON[cnt]);
    assign cache_hit = KEY_CACHE_EN && cache_valid && (key_in == cache_key);

    aes_inv_round u_round (
        .st   (st),
        .rk   (rk_prev),
        .last (cnt == 4'd1),
        .nxt  (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            st          <= '0;
            rk          <= '0;
            key_reg     <= '0;
            cache_key   <= '0;
            rk10_cache  <= '0;
            cache_valid <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            pt_out      <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_ready && in_valid) begin
                        st       <= ct_in;
                        key_reg  <= key_in;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (cache_hit) begin
                            rk    <= rk10_cache;
                            state <= ST_INIT;
                        end else begin
                            rk    <= key_in;
                            cnt   <= 4'd1;
                            state <= ST_KEYEXP;
                        end
                    end
                end
                ST_KEYEXP: begin
                    rk <= rk_fwd;
                    if (cnt == 4'd10) begin
                        rk10_cache  <= rk_fwd;
                        cache_key   <= key_reg;
                        cache_valid <= 1'b1;
                        state       <= ST_INIT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_INIT: begin
                    st    <= st ^ rk;
                    cnt   <= 4'd10;
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    // cnt==0 is the extra edge that publishes the finished state.
                    if (cnt == 4'd0) begin
                        pt_out    <= st;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        st  <= round_out;
                        rk  <= rk_prev;
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
